legv8_multicycle_cpu: RTL and testbench

Parametrised multicycle successor to the single-cycle LEGv8 core. Executes one instruction over 3–5 states, sharing one ALU, with a register file and instruction fetch inside the block. Instruction and data memories sit outside the block behind req/ready handshakes, so wait-state memories can be used. It is the top-level core for the multicycle build, sitting between external imem/dmem models and the testbench.

---
 rtl/legv8_multicycle_cpu.sv | 167 ++++++++++++++++
 tb/tb_legv8_multicycle_cpu.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/legv8_multicycle_cpu.sv
// Multicycle LEGv8 core: FETCH/DECODE/EXEC/MEM/WB/HALT sequencer with one shared ALU and req/ready memory ports.
// Optional LEGV8_MC_PERF_EN adds 64-bit cycle and retired-instruction counters.
module legv8_multicycle_cpu #(
    parameter int              DATA_W   = 64,
    parameter int              PC_W     = 64,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ready,
    input  logic [31:0]       imem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [PC_W-1:0]   dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ready,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic [PC_W-1:0]   pc,
    output logic              retire,
    output logic              halt
`ifdef LEGV8_MC_PERF_EN
    ,
    output logic [63:0]       perf_cycles,
    output logic [63:0]       perf_instret
`endif
);

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

    state_t              r_state, w_next;
    logic [PC_W-1:0]     r_pc;
    logic [31:0]         r_ir;
    logic [DATA_W-1:0]   r_a, r_b, r_result;
    logic [PC_W-1:0]     r_addr;
    logic [DATA_W-1:0]   r_regs [0:30];

    logic [10:0]         w_op;
    logic                w_is_add, w_is_sub, w_is_and, w_is_orr;
    logic                w_is_ldur, w_is_stur, w_is_cbz, w_is_b, w_is_rtype, w_legal;
    logic [4:0]          w_rb_idx;
    logic [DATA_W-1:0]   w_rd_a, w_rd_b, w_alu_res, w_dimm, w_mem_sum;
    logic [PC_W-1:0]     w_mem_addr, w_b_off, w_cb_off, w_pc4;

    assign w_op       = r_ir[31:21];
    assign w_is_add   = (w_op == 11'b10001011000);
    assign w_is_sub   = (w_op == 11'b11001011000);
    assign w_is_and   = (w_op == 11'b10001010000);
    assign w_is_orr   = (w_op == 11'b10101010000);
    assign w_is_ldur  = (w_op == 11'b11111000010);
    assign w_is_stur  = (w_op == 11'b11111000000);
    assign w_is_cbz   = (r_ir[31:24] == 8'b10110100);
    assign w_is_b     = (r_ir[31:26] == 6'b000101);
    assign w_is_rtype = w_is_add | w_is_sub | w_is_and | w_is_orr;
    assign w_legal    = w_is_rtype | w_is_ldur | w_is_stur | w_is_cbz | w_is_b;

    // STUR and CBZ take their second operand from the Rt field
    assign w_rb_idx = (w_is_stur | w_is_cbz) ? r_ir[4:0] : r_ir[20:16];
    assign w_rd_a   = (r_ir[9:5] == 5'd31) ? '0 : r_regs[r_ir[9:5]];
    assign w_rd_b   = (w_rb_idx == 5'd31) ? '0 : r_regs[w_rb_idx];

    assign w_dimm     = DATA_W'($signed(r_ir[20:12]));
    assign w_mem_sum  = r_a + w_dimm;
    assign w_mem_addr = PC_W'($signed(w_mem_sum));
    assign w_b_off    = PC_W'($signed(r_ir[25:0])) << 2;
    assign w_cb_off   = PC_W'($signed(r_ir[23:5])) << 2;
    assign w_pc4      = r_pc + PC_W'(4);

    always_comb begin
        w_alu_res = r_a + r_b;
        if (w_is_sub)      w_alu_res = r_a - r_b;
        else if (w_is_and) w_alu_res = r_a & r_b;
        else if (w_is_orr) w_alu_res = r_a | r_b;
    end

    always_ff @(posedge clock) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:  if (imem_ready) w_next = S_DECODE;
            S_DECODE: w_next = w_legal ? S_EXEC : S_HALT;
            S_EXEC: begin
                if (w_is_rtype)                  w_next = S_WB;
                else if (w_is_ldur || w_is_stur) w_next = S_MEM;
                else                             w_next = S_FETCH;
            end
            S_MEM:    if (dmem_ready) w_next = w_is_stur ? S_FETCH : S_WB;
            S_WB:     w_next = S_FETCH;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_FETCH;
        endcase
    end

    always_comb begin
        imem_req = (r_state == S_FETCH);
        dmem_req = (r_state == S_MEM);
        dmem_we  = (r_state == S_MEM) && w_is_stur;
        halt     = (r_state == S_HALT);
        retire   = ((r_state == S_EXEC) && (w_is_b || w_is_cbz))
                 || ((r_state == S_MEM) && dmem_ready && w_is_stur)
                 || (r_state == S_WB);
    end

    assign imem_addr  = r_pc;
    assign dmem_addr  = r_addr;
    assign dmem_wdata = r_b;
    assign pc         = r_pc;

    always_ff @(posedge clock) begin
        case (r_state)
            S_FETCH:  if (imem_ready) r_ir <= imem_rdata;
            S_DECODE: begin
                r_a <= w_rd_a;
                r_b <= w_rd_b;
            end
            S_EXEC: begin
                if (w_is_rtype)              r_result <= w_alu_res;
                if (w_is_ldur || w_is_stur)  r_addr   <= w_mem_addr;
            end
            S_MEM:    if (dmem_ready && !w_is_stur) r_result <= dmem_rdata;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else begin
            case (r_state)
                S_EXEC: begin
                    if (w_is_b)        r_pc <= r_pc + w_b_off;
                    else if (w_is_cbz) r_pc <= (r_b == '0) ? r_pc + w_cb_off : w_pc4;
                end
                S_MEM:   if (dmem_ready && w_is_stur) r_pc <= w_pc4;
                S_WB:    r_pc <= w_pc4;
                default: ;
            endcase
        end
    end

    // Writes aimed at X31 (XZR) are dropped
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 31; i++) r_regs[i] <= '0;
        end else if (r_state == S_WB && r_ir[4:0] != 5'd31) begin
            r_regs[r_ir[4:0]] <= r_result;
        end
    end

`ifdef LEGV8_MC_PERF_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_cycles  <= '0;
            perf_instret <= '0;
        end else begin
            if (r_state != S_HALT) perf_cycles  <= perf_cycles + 64'd1;
            if (retire)            perf_instret <= perf_instret + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_legv8_multicycle_cpu.sv
// Directed bench for legv8_multicycle_cpu: a table of instructions with hand-computed results,
// plus hand-written reset, halt and reset-during-MEM sequences.
module tb_legv8_multicycle_cpu;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam int NV = 24;

    logic        clock = 1'b0;
    logic        reset;
    logic        imem_req, imem_ready;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        dmem_req, dmem_we, dmem_ready;
    logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [63:0] pc;
    logic        retire, halt;
`ifdef LEGV8_MC_PERF_EN
    logic [63:0] perf_cycles, perf_instret;
`endif

    legv8_multicycle_cpu #(.DATA_W(64), .PC_W(64), .RESET_PC(64'h100)) dut (
        .clock(clock), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .pc(pc), .retire(retire), .halt(halt)
`ifdef LEGV8_MC_PERF_EN
        , .perf_cycles(perf_cycles), .perf_instret(perf_instret)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [63:0] pc0;
        logic [31:0] instr;
        int          iw;
        int          dw;
        logic [63:0] ld;
        int          cyc;
        logic [63:0] pc1;
        bit          mem;
        bit          we;
        logic [63:0] addr;
        logic [63:0] wdata;
    } vec_t;

    vec_t vt [NV];
    int   ncmp = 0;
    int   nerr = 0;
    int   nret = 0;

    function automatic logic [31:0] enc_r(input logic [10:0] op, input int rm, input int rn, input int rd);
        return {op, 5'(rm), 6'b0, 5'(rn), 5'(rd)};
    endfunction
    function automatic logic [31:0] enc_d(input logic [10:0] op, input int imm, input int rn, input int rt);
        return {op, 9'(imm), 2'b00, 5'(rn), 5'(rt)};
    endfunction
    function automatic logic [31:0] enc_cbz(input int imm, input int rt);
        return {8'b10110100, 19'(imm), 5'(rt)};
    endfunction
    function automatic logic [31:0] enc_b(input int imm);
        return {6'b000101, 26'(imm)};
    endfunction

    function automatic vec_t mk(input logic [63:0] pc0, input logic [31:0] instr, input int iw, input int dw,
                                input logic [63:0] ld, input int cyc, input logic [63:0] pc1, input bit mem,
                                input bit we, input logic [63:0] addr, input logic [63:0] wdata);
        vec_t v;
        v.pc0 = pc0; v.instr = instr; v.iw = iw; v.dw = dw; v.ld = ld; v.cyc = cyc;
        v.pc1 = pc1; v.mem = mem; v.we = we; v.addr = addr; v.wdata = wdata;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drives one instruction through fetch and any data access, acting as zero/wait-state memories.
    task automatic exec_instr(input logic [31:0] instr, input int iw, input int dw, input logic [63:0] ld,
                              input logic [63:0] pc0, input int rst_at,
                              output int cyc, output logic [63:0] pc1, output bit saw_d,
                              output logic [63:0] a, output logic [63:0] w, output logic we,
                              output bit stable, output bit fetch_ok, output bit done);
        int icnt;
        int dcnt;
        icnt = 0; dcnt = 0;
        cyc = 0; done = 0; saw_d = 0; stable = 1; fetch_ok = 1; a = '0; w = '0; we = 1'b0;
        while (!done && cyc < 64) begin
            @(negedge clock);
            cyc++;
            imem_ready = 1'b0;
            dmem_ready = 1'b0;
            if (imem_req) begin
                if (imem_addr !== pc0) fetch_ok = 0;
                imem_rdata = instr;
                imem_ready = (icnt >= iw);
                icnt++;
            end
            if (dmem_req) begin
                if (!saw_d) begin
                    a = dmem_addr; w = dmem_wdata; we = dmem_we; saw_d = 1;
                end else if (a !== dmem_addr || w !== dmem_wdata || we !== dmem_we) begin
                    stable = 0;
                end
                if (dcnt == rst_at) begin
                    reset = 1'b1;
                    done  = 1;
                end else begin
                    dmem_rdata = ld;
                    dmem_ready = (dcnt >= dw);
                end
                dcnt++;
            end
            #1;
            if (retire) begin
                nret++;
                done = 1;
            end
            if (halt) done = 1;
        end
        @(posedge clock);
        #1;
        pc1 = pc;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int          cyc;
        logic [63:0] pc1, a, w;
        logic        we;
        bit          saw_d, stable, fetch_ok, done;
        exec_instr(v.instr, v.iw, v.dw, v.ld, v.pc0, -1, cyc, pc1, saw_d, a, w, we, stable, fetch_ok, done);
        chk($sformatf("v%0d_done", idx), 64'(done), 64'd1);
        chk($sformatf("v%0d_cycles", idx), 64'(cyc), 64'(v.cyc));
        chk($sformatf("v%0d_pc_next", idx), pc1, v.pc1);
        chk($sformatf("v%0d_fetch_addr", idx), 64'(fetch_ok), 64'd1);
        chk($sformatf("v%0d_dmem_req", idx), 64'(saw_d), 64'(v.mem));
        if (v.mem) begin
            chk($sformatf("v%0d_dmem_addr", idx), a, v.addr);
            chk($sformatf("v%0d_dmem_we", idx), 64'(we), 64'(v.we));
            chk($sformatf("v%0d_dmem_stable", idx), 64'(stable), 64'd1);
            if (v.we) chk($sformatf("v%0d_dmem_wdata", idx), w, v.wdata);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          bad;
        int          cyc;
        logic [63:0] pc1, a, w;
        logic        we;
        bit          saw_d, stable, fetch_ok, done;
`ifdef LEGV8_MC_PERF_EN
        logic [63:0] snap;
`endif

        vt[0]  = mk(64'h100, enc_d(OP_LDUR, 0, 31, 1), 0, 0, 64'd5, 5, 64'h104, 1, 0, 64'd0, 64'd0);
        vt[1]  = mk(64'h104, enc_d(OP_LDUR, 0, 31, 2), 2, 0, 64'd3, 7, 64'h108, 1, 0, 64'd0, 64'd0);
        vt[2]  = mk(64'h108, enc_r(OP_SUB, 2, 1, 3), 0, 0, 64'd0, 4, 64'h10C, 0, 0, 64'd0, 64'd0);
        vt[3]  = mk(64'h10C, enc_d(OP_STUR, 8, 1, 3), 0, 3, 64'd0, 7, 64'h110, 1, 1, 64'd13, 64'd2);
        vt[4]  = mk(64'h110, enc_d(OP_LDUR, 8, 1, 4), 0, 3, 64'd2, 8, 64'h114, 1, 0, 64'd13, 64'd0);
        vt[5]  = mk(64'h114, enc_d(OP_STUR, -8, 31, 4), 0, 0, 64'd0, 4, 64'h118, 1, 1, 64'hFFFF_FFFF_FFFF_FFF8, 64'd2);
        vt[6]  = mk(64'h118, enc_r(OP_ADD, 2, 1, 5), 0, 0, 64'd0, 4, 64'h11C, 0, 0, 64'd0, 64'd0);
        vt[7]  = mk(64'h11C, enc_r(OP_AND, 2, 1, 6), 0, 0, 64'd0, 4, 64'h120, 0, 0, 64'd0, 64'd0);
        vt[8]  = mk(64'h120, enc_r(OP_ORR, 2, 1, 7), 1, 0, 64'd0, 5, 64'h124, 0, 0, 64'd0, 64'd0);
        vt[9]  = mk(64'h124, enc_d(OP_STUR, 0, 31, 5), 0, 0, 64'd0, 4, 64'h128, 1, 1, 64'd0, 64'd8);
        vt[10] = mk(64'h128, enc_d(OP_STUR, 1, 31, 6), 0, 0, 64'd0, 4, 64'h12C, 1, 1, 64'd1, 64'd1);
        vt[11] = mk(64'h12C, enc_d(OP_STUR, 2, 31, 7), 0, 0, 64'd0, 4, 64'h130, 1, 1, 64'd2, 64'd7);
        vt[12] = mk(64'h130, enc_r(OP_ADD, 2, 1, 31), 0, 0, 64'd0, 4, 64'h134, 0, 0, 64'd0, 64'd0);
        vt[13] = mk(64'h134, enc_d(OP_STUR, 0, 2, 31), 0, 0, 64'd0, 4, 64'h138, 1, 1, 64'd3, 64'd0);
        vt[14] = mk(64'h138, enc_r(OP_SUB, 1, 31, 8), 0, 0, 64'd0, 4, 64'h13C, 0, 0, 64'd0, 64'd0);
        vt[15] = mk(64'h13C, enc_d(OP_STUR, 0, 31, 8), 0, 0, 64'd0, 4, 64'h140, 1, 1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB);
        vt[16] = mk(64'h140, enc_d(OP_LDUR, 0, 31, 9), 0, 0, 64'h8000_0000_0000_0001, 5, 64'h144, 1, 0, 64'd0, 64'd0);
        vt[17] = mk(64'h144, enc_r(OP_ADD, 9, 9, 10), 0, 0, 64'd0, 4, 64'h148, 0, 0, 64'd0, 64'd0);
        vt[18] = mk(64'h148, enc_d(OP_STUR, 0, 31, 10), 0, 0, 64'd0, 4, 64'h14C, 1, 1, 64'd0, 64'd2);
        vt[19] = mk(64'h14C, enc_b(-75), 0, 0, 64'd0, 3, 64'h20, 0, 0, 64'd0, 64'd0);
        vt[20] = mk(64'h20, enc_cbz(-2, 31), 0, 0, 64'd0, 3, 64'h18, 0, 0, 64'd0, 64'd0);
        vt[21] = mk(64'h18, enc_b(2), 0, 0, 64'd0, 3, 64'h20, 0, 0, 64'd0, 64'd0);
        vt[22] = mk(64'h20, enc_cbz(-2, 1), 0, 0, 64'd0, 3, 64'h24, 0, 0, 64'd0, 64'd0);
        vt[23] = mk(64'h24, 32'hFFFF_FFFF, 0, 0, 64'd0, 3, 64'h24, 0, 0, 64'd0, 64'd0);

        reset = 1'b1;
        imem_ready = 1'b0; imem_rdata = '0;
        dmem_ready = 1'b0; dmem_rdata = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_pc", pc, 64'h100);
        chk("rst_imem_req", 64'(imem_req), 64'd1);
        chk("rst_dmem_req", 64'(dmem_req), 64'd0);
        chk("rst_halt", 64'(halt), 64'd0);
        chk("rst_retire", 64'(retire), 64'd0);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) run_vec(i, vt[i]);

        // Halted core must stay quiet and keep its pc
        chk("halt_flag", 64'(halt), 64'd1);
`ifdef LEGV8_MC_PERF_EN
        snap = perf_cycles;
`endif
        bad = 0;
        repeat (8) begin
            @(negedge clock);
            if (imem_req || dmem_req || retire || !halt) bad++;
        end
        chk("halt_quiet", 64'(bad), 64'd0);
        chk("halt_pc", pc, 64'h24);
`ifdef LEGV8_MC_PERF_EN
        chk("perf_cycles_frozen", perf_cycles, snap);
        chk("perf_instret", perf_instret, 64'(nret));
`endif

        // Reset out of HALT, reload X1, then reset in the middle of a store's wait states
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk("rehalt_halt", 64'(halt), 64'd0);
        chk("rehalt_pc", pc, 64'h100);
        reset = 1'b0;
        run_vec(100, mk(64'h100, enc_d(OP_LDUR, 0, 31, 1), 0, 0, 64'd5, 5, 64'h104, 1, 0, 64'd0, 64'd0));

        exec_instr(enc_d(OP_STUR, 0, 31, 1), 0, 10, 64'd0, 64'h104, 2,
                   cyc, pc1, saw_d, a, w, we, stable, fetch_ok, done);
        chk("midmem_saw_store", 64'(saw_d), 64'd1);
        chk("midmem_wdata_before", w, 64'd5);
        chk("midmem_dmem_req", 64'(dmem_req), 64'd0);
        chk("midmem_pc", pc1, 64'h100);
        chk("midmem_imem_req", 64'(imem_req), 64'd1);
        chk("midmem_retire", 64'(retire), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        run_vec(101, mk(64'h100, enc_d(OP_STUR, 0, 31, 1), 0, 0, 64'd0, 4, 64'h104, 1, 1, 64'd0, 64'd0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
